// File: rtl/iq_sample_packer.sv
// Buffers one {I,Q} sample per strobe in a FIFO and emits it as 4 bytes (16-bit words, I first).
// Latency: first byte valid one cycle after the FIFO write; byte_valid holds until byte_ready, FIFO absorbs stalls.
module iq_sample_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   i_in,
  input  logic [15:0]                   q_in,
  input  logic                          sample_valid,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [CNT_W-1:0]              sample_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q, level;
  logic [31:0]       shift_q, shift_d, rd_dat;
  logic [7:0]        byte_q, byte_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full, empty, pop, push, drop, accept;

  // Sample word layout is {I,Q}; idx walks the four output byte slots in emit order.
  function automatic logic [7:0] sel_byte(input logic [31:0] s, input logic [1:0] idx);
    logic [15:0] w;
    logic        hi;
    w  = idx[1] ? s[15:0] : s[31:16];
    hi = (BIG_ENDIAN != 0) ? ~idx[0] : idx[0];
    return hi ? w[15:8] : w[7:0];
  endfunction

  assign level  = wr_ptr_q - rd_ptr_q;
  assign full   = (level == (AW+1)'(FIFO_DEPTH));
  assign empty  = (level == '0);
  assign accept = (state_q != IDLE) && byte_ready;
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push   = sample_valid & enable & (~full | pop);
  assign drop   = sample_valid & enable & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {i_in, q_in};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = B0;
        shift_d = rd_dat;
        byte_d  = sel_byte(rd_dat, 2'd0);
      end
      B0: if (accept) begin
        state_d = B1;
        byte_d  = sel_byte(shift_q, 2'd1);
      end
      B1: if (accept) begin
        state_d = B2;
        byte_d  = sel_byte(shift_q, 2'd2);
      end
      B2: if (accept) begin
        state_d = B3;
        byte_d  = sel_byte(shift_q, 2'd3);
      end
      B3: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = B0;
          shift_d = rd_dat;
          byte_d  = sel_byte(rd_dat, 2'd0);
        end else begin
          state_d = IDLE;
          byte_d  = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign byte_out     = byte_q;
  assign byte_valid   = (state_q != IDLE);
  assign overflow     = ovf_q;
  assign sample_count = cnt_q;
  assign fifo_level   = level;

endmodule
